// File: rtl/frame_rr_scheduler_pkg.sv
// Shared constants and types for the frame round-robin scheduler.
//  FIFO_W / EOF_BIT : FIFO word layout, [7:0] byte, [8] end-of-frame
//  state_t          : scheduler FSM encoding
//  fifo_word_t      : FIFO word payload as a packed struct
package frame_rr_scheduler_pkg;

    localparam int unsigned FIFO_W  = 9;
    localparam int unsigned EOF_BIT = 8;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic              eof;
        logic [BYTE_W-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/frame_rr_scheduler_if.sv
// Bus bundle between two rx FIFO read sides, one tx FIFO write side and the scheduler.
//  slave  : scheduler view (drives pops, the tx write, grant and statistics)
//  master : environment view (drives FIFO status/data and enable)
interface frame_rr_scheduler_if #(
    parameter int unsigned CNT_W = 16
);
    import frame_rr_scheduler_pkg::*;

    logic             enable;
    logic             rd0_en;
    fifo_word_t       rd0_data;
    logic             rd0_empty;
    logic             rd1_en;
    fifo_word_t       rd1_data;
    logic             rd1_empty;
    logic             wr_en;
    fifo_word_t       wr_data;
    logic             wr_full;
    logic [1:0]       grant;
    logic [CNT_W-1:0] frame_cnt0;
    logic [CNT_W-1:0] frame_cnt1;
    logic [CNT_W-1:0] trunc_cnt;

    modport slave (
        input  enable, rd0_data, rd0_empty, rd1_data, rd1_empty, wr_full,
        output rd0_en, rd1_en, wr_en, wr_data, grant, frame_cnt0, frame_cnt1, trunc_cnt
    );

    modport master (
        output enable, rd0_data, rd0_empty, rd1_data, rd1_empty, wr_full,
        input  rd0_en, rd1_en, wr_en, wr_data, grant, frame_cnt0, frame_cnt1, trunc_cnt
    );

endinterface

// File: rtl/frame_rr_scheduler_rr_pick2.sv
// Combinational 2-way round-robin select.
//  i_req    : request per port (bit 0 = port 0)
//  i_last   : port that owned the previous frame
//  o_gnt_c  : one-hot pick, 0 when nothing requests
module frame_rr_scheduler_rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt_c
);

    // With both requesting, the port that did not go last wins.
    always_comb begin
        o_gnt_c = 2'b00;
        case (i_req)
            2'b01:   o_gnt_c = 2'b01;
            2'b10:   o_gnt_c = 2'b10;
            2'b11:   o_gnt_c = i_last ? 2'b01 : 2'b10;
            default: o_gnt_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/frame_rr_scheduler.sv
// Frame-granular round-robin merge of two FWFT rx FIFOs onto one tx FIFO write port.
// Frames are never interleaved; frames longer than MAX_LEN are cut, marked EOF and the
// remainder is drained from the source FIFO without being written.
//  sys_clk / reset_n : clock, asynchronous active-low reset
//  io_bus.enable     : allow new grants (a frame in progress always completes)
//  io_bus.rd*_*      : rx FIFO read sides; rd*_en pops the presented word combinationally
//  io_bus.wr_*       : tx FIFO write side; wr_en/wr_data registered, wr_full is programmable-full
//  io_bus.grant      : one-hot owner of the current frame
//  io_bus.*_cnt      : forwarded-frame and truncated-frame statistics (wrapping)
module frame_rr_scheduler
    import frame_rr_scheduler_pkg::*;
#(
    parameter int unsigned MAX_LEN = 1522,
    parameter int unsigned LEN_W   = 11,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                  sys_clk,
    input  logic                  reset_n,
    frame_rr_scheduler_if.slave   io_bus
);

    state_t           r_state,      w_state_nxt;
    logic [1:0]       r_grant,      w_grant_nxt;
    logic             r_last,       w_last_nxt;
    logic [LEN_W-1:0] r_len,        w_len_nxt;
    logic             r_wr_en,      w_wr_en_nxt;
    fifo_word_t       r_wr_data,    w_wr_data_nxt;
    logic [CNT_W-1:0] r_frame_cnt0, w_frame_cnt0_nxt;
    logic [CNT_W-1:0] r_frame_cnt1, w_frame_cnt1_nxt;
    logic [CNT_W-1:0] r_trunc_cnt,  w_trunc_cnt_nxt;

    logic [1:0]       w_pick;
    logic             w_sel1;
    logic             w_g_empty;
    fifo_word_t       w_g_word;
    logic             w_pop;

    frame_rr_scheduler_rr_pick2 u_rr_pick2 (
        .i_req   ({~io_bus.rd1_empty, ~io_bus.rd0_empty}),
        .i_last  (r_last),
        .o_gnt_c (w_pick)
    );

    // Granted port's FIFO view; grant is 0 in IDLE where no pop happens anyway.
    assign w_sel1    = r_grant[1];
    assign w_g_empty = w_sel1 ? io_bus.rd1_empty : io_bus.rd0_empty;
    assign w_g_word  = w_sel1 ? io_bus.rd1_data  : io_bus.rd0_data;

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_grant      <= 2'b00;
            r_last       <= 1'b1;
            r_len        <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_frame_cnt0 <= '0;
            r_frame_cnt1 <= '0;
            r_trunc_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_last       <= w_last_nxt;
            r_len        <= w_len_nxt;
            r_wr_en      <= w_wr_en_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_frame_cnt0 <= w_frame_cnt0_nxt;
            r_frame_cnt1 <= w_frame_cnt1_nxt;
            r_trunc_cnt  <= w_trunc_cnt_nxt;
        end
    end

    // Next-state, pop and write decisions.
    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_last_nxt       = r_last;
        w_len_nxt        = r_len;
        w_wr_en_nxt      = 1'b0;
        w_wr_data_nxt    = r_wr_data;
        w_frame_cnt0_nxt = r_frame_cnt0;
        w_frame_cnt1_nxt = r_frame_cnt1;
        w_trunc_cnt_nxt  = r_trunc_cnt;
        w_pop            = 1'b0;

        case (r_state)
            IDLE: begin
                if (io_bus.enable && (w_pick != 2'b00)) begin
                    w_grant_nxt = w_pick;
                    w_len_nxt   = '0;
                    w_state_nxt = FWD;
                end
            end

            FWD: begin
                // wr_full leaves one free entry, enough for the write already in flight.
                w_pop = !w_g_empty && !io_bus.wr_full;
                if (w_pop) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_data_nxt = w_g_word;
                    w_len_nxt     = r_len + LEN_W'(1);
                    if (w_g_word.eof || (r_len == LEN_W'(MAX_LEN - 1))) begin
                        w_last_nxt = w_sel1;
                        if (w_sel1) w_frame_cnt1_nxt = r_frame_cnt1 + CNT_W'(1);
                        else        w_frame_cnt0_nxt = r_frame_cnt0 + CNT_W'(1);
                        if (w_g_word.eof) begin
                            w_grant_nxt = 2'b00;
                            w_state_nxt = IDLE;
                        end else begin
                            // MAX_LEN-th byte without EOF: close the frame here, drop the rest.
                            w_wr_data_nxt.eof = 1'b1;
                            w_trunc_cnt_nxt   = r_trunc_cnt + CNT_W'(1);
                            w_state_nxt       = DRAIN;
                        end
                    end
                end
            end

            DRAIN: begin
                w_pop = !w_g_empty;
                if (w_pop && w_g_word.eof) begin
                    w_grant_nxt = 2'b00;
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_grant_nxt = 2'b00;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign io_bus.rd0_en     = w_pop & ~w_sel1;
    assign io_bus.rd1_en     = w_pop &  w_sel1;
    assign io_bus.wr_en      = r_wr_en;
    assign io_bus.wr_data    = r_wr_data;
    assign io_bus.grant      = r_grant;
    assign io_bus.frame_cnt0 = r_frame_cnt0;
    assign io_bus.frame_cnt1 = r_frame_cnt1;
    assign io_bus.trunc_cnt  = r_trunc_cnt;

endmodule

// File: tb/tb_frame_rr_scheduler.sv
// Self-checking bench for frame_rr_scheduler: FIFO models on both sides, a frame-level
// reference model of the round-robin/truncation rules, and protocol monitors.
`timescale 1ns/1ps
module tb_frame_rr_scheduler;
    import frame_rr_scheduler_pkg::*;

    localparam int unsigned MAX_LEN  = 1522;
    localparam int unsigned LEN_W    = 11;
    localparam int unsigned CNT_W    = 16;
    localparam int          TX_DEPTH = 4;

    logic sys_clk = 1'b0;
    logic reset_n;

    frame_rr_scheduler_if #(.CNT_W(CNT_W)) bus ();

    frame_rr_scheduler #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .io_bus  (bus.slave)
    );

    always #4 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // rx FIFO contents, captured tx writes, owner of each granted frame
    logic [8:0] rxq0[$];
    logic [8:0] rxq1[$];
    logic [8:0] outq[$];
    int         gseq[$];

    // reference model inputs (frames as lengths + bytes) and outputs
    int         mlen0[$];
    int         mlen1[$];
    logic [7:0] mbyte0[$];
    logic [7:0] mbyte1[$];
    logic [8:0] expq[$];
    int         exp_order[$];
    int         exp_cnt0, exp_cnt1, exp_trunc;

    bit         force_full;
    bit         drain_all;
    int         tx_occ;
    int         mon_both, mon_pop_full, mon_lat, mon_ovf, mon_bad_grant;
    int         mon_run, mon_max_run;
    bit         prev_pop;
    logic [1:0] prev_grant;

    // Present FIFO heads and tx full flag; changes land just after the clock edge.
    always @(posedge sys_clk) begin
        bus.rd0_empty <= (rxq0.size() == 0);
        if (rxq0.size() != 0) bus.rd0_data <= rxq0[0];
        else                  bus.rd0_data <= '0;
        bus.rd1_empty <= (rxq1.size() == 0);
        if (rxq1.size() != 0) bus.rd1_data <= rxq1[0];
        else                  bus.rd1_data <= '0;
        bus.wr_full   <= force_full || (tx_occ >= TX_DEPTH - 1);
    end

    // Mid-cycle monitor: pops, tx capture, tx occupancy model and protocol checks.
    always @(negedge sys_clk) begin
        if (!reset_n) begin
            prev_pop   = 1'b0;
            prev_grant = 2'b00;
            mon_run    = 0;
        end else begin
            if (bus.rd0_en && bus.rd1_en) mon_both++;
            if ((bus.rd0_en || bus.rd1_en) && bus.wr_full) mon_pop_full++;
            if (bus.wr_en && !prev_pop) mon_lat++;
            if (!(bus.grant inside {2'b00, 2'b01, 2'b10})) mon_bad_grant++;
            if (bus.grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(bus.grant == 2'b10 ? 1 : 0);
            if (bus.wr_en) begin
                outq.push_back(bus.wr_data);
                mon_run++;
                if (mon_run > mon_max_run) mon_max_run = mon_run;
                if (tx_occ >= TX_DEPTH) mon_ovf++;
                else tx_occ++;
            end else begin
                mon_run = 0;
            end
            if (tx_occ > 0 && (drain_all || $urandom_range(1, 0) == 1)) tx_occ--;
            if (bus.rd0_en && rxq0.size() != 0) void'(rxq0.pop_front());
            if (bus.rd1_en && rxq1.size() != 0) void'(rxq1.pop_front());
            prev_pop   = bus.rd0_en || bus.rd1_en;
            prev_grant = bus.grant;
        end
    end

    task automatic push_frame(input int port, input int len);
        logic [7:0] b;
        logic [8:0] w;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            w = {(i == len - 1), b};
            if (port == 0) begin rxq0.push_back(w); mbyte0.push_back(b); end
            else           begin rxq1.push_back(w); mbyte1.push_back(b); end
        end
        if (port == 0) mlen0.push_back(len);
        else           mlen1.push_back(len);
    endtask

    // Frame-level reference: pick order, truncated output stream and counter values.
    task automatic run_model(input int first_last);
        int last;
        int p;
        int len;
        int n;
        logic [7:0] b;
        last = first_last;
        expq.delete();
        exp_order.delete();
        exp_cnt0 = 0; exp_cnt1 = 0; exp_trunc = 0;
        while (mlen0.size() + mlen1.size() > 0) begin
            if (mlen0.size() > 0 && mlen1.size() > 0) p = 1 - last;
            else p = (mlen0.size() > 0) ? 0 : 1;
            len = (p == 1) ? mlen1.pop_front() : mlen0.pop_front();
            n = (len > int'(MAX_LEN)) ? int'(MAX_LEN) : len;
            for (int i = 0; i < len; i++) begin
                b = (p == 1) ? mbyte1.pop_front() : mbyte0.pop_front();
                if (i < n) expq.push_back({(i == n - 1), b});
            end
            if (len > int'(MAX_LEN)) exp_trunc++;
            if (p == 1) exp_cnt1++; else exp_cnt0++;
            exp_order.push_back(p);
            last = p;
        end
    endtask

    function automatic int stream_errors();
        int e = 0;
        if (outq.size() != expq.size()) e++;
        for (int i = 0; i < outq.size() && i < expq.size(); i++)
            if (outq[i] !== expq[i]) e++;
        return e;
    endfunction

    function automatic int order_errors();
        int e = 0;
        if (gseq.size() != exp_order.size()) e++;
        for (int i = 0; i < gseq.size() && i < exp_order.size(); i++)
            if (gseq[i] != exp_order[i]) e++;
        return e;
    endfunction

    task automatic clear_env();
        rxq0.delete(); rxq1.delete(); outq.delete(); gseq.delete();
        mlen0.delete(); mlen1.delete(); mbyte0.delete(); mbyte1.delete();
        tx_occ = 0; force_full = 1'b0; drain_all = 1'b1;
        mon_both = 0; mon_pop_full = 0; mon_lat = 0; mon_ovf = 0; mon_bad_grant = 0;
        mon_run = 0; mon_max_run = 0;
    endtask

    task automatic do_reset();
        bus.enable = 1'b0;
        reset_n    = 1'b0;
        clear_env();
        repeat (3) @(posedge sys_clk);
        #1 reset_n = 1'b1;
    endtask

    // Bounded wait for both rx FIFOs empty and the scheduler idle with no write pending.
    task automatic wait_idle(input int budget, input string tag);
        int  c = 0;
        bit  done = 1'b0;
        while (!done && c < budget) begin
            @(negedge sys_clk); #1;
            c++;
            if (rxq0.size() == 0 && rxq1.size() == 0 && bus.grant == 2'b00 && !bus.wr_en) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: not idle after %0d cycles (rx0=%0d rx1=%0d grant=%b)",
                     tag, c, rxq0.size(), rxq1.size(), bus.grant);
        end
    endtask

    task automatic test_reset();
        bus.enable = 1'b0;
        reset_n    = 1'b0;
        clear_env();
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk); #1;
        n_tests++; if (bus.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", bus.grant); end
        n_tests++; if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", bus.wr_en); end
        n_tests++; if (bus.wr_data !== 9'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h want 000", bus.wr_data); end
        n_tests++; if ({bus.rd0_en, bus.rd1_en} !== 2'b00) begin n_fail++; $display("FAIL reset_rd_en: got %b want 00", {bus.rd0_en, bus.rd1_en}); end
        n_tests++; if (bus.frame_cnt0 !== '0 || bus.frame_cnt1 !== '0 || bus.trunc_cnt !== '0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", bus.frame_cnt0, bus.frame_cnt1, bus.trunc_cnt);
        end
        @(posedge sys_clk); #1 reset_n = 1'b1;
        repeat (3) @(negedge sys_clk); #1;
        n_tests++; if (bus.grant !== 2'b00 || bus.wr_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle_empty: got grant=%b wr_en=%b want 00/0", bus.grant, bus.wr_en);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        push_frame(0, 64);
        run_model(1);
        bus.enable = 1'b1;
        wait_idle(400, "single");
        n_tests++; if (stream_errors() != 0) begin n_fail++; $display("FAIL single_stream: got %0d word errors want 0", stream_errors()); end
        n_tests++; if (mon_max_run != 64) begin n_fail++; $display("FAIL single_consecutive: got run %0d want 64", mon_max_run); end
        n_tests++; if (outq.size() != 64 || outq[63][EOF_BIT] !== 1'b1) begin n_fail++; $display("FAIL single_eof: got %0d words want 64 ending in EOF", outq.size()); end
        n_tests++; if (bus.frame_cnt0 !== 16'd1 || bus.frame_cnt1 !== 16'd0) begin
            n_fail++; $display("FAIL single_cnt: got %0d/%0d want 1/0", bus.frame_cnt0, bus.frame_cnt1);
        end
        n_tests++; if (gseq.size() != 1 || gseq[0] != 0) begin n_fail++; $display("FAIL single_grant: got %0d grants want 1 to port 0", gseq.size()); end
        n_tests++; if (mon_lat != 0) begin n_fail++; $display("FAIL single_latency: got %0d writes without prior pop want 0", mon_lat); end
    endtask

    task automatic test_alternate();
        do_reset();
        for (int i = 0; i < 3; i++) begin push_frame(0, 60); push_frame(1, 60); end
        run_model(1);
        bus.enable = 1'b1;
        wait_idle(800, "alternate");
        n_tests++; if (order_errors() != 0) begin n_fail++; $display("FAIL alt_order: got %0d order errors (%0d frames) want 0", order_errors(), gseq.size()); end
        n_tests++; if (stream_errors() != 0) begin n_fail++; $display("FAIL alt_stream: got %0d word errors want 0", stream_errors()); end
        n_tests++; if (bus.frame_cnt0 !== 16'd3 || bus.frame_cnt1 !== 16'd3) begin
            n_fail++; $display("FAIL alt_cnt: got %0d/%0d want 3/3", bus.frame_cnt0, bus.frame_cnt1);
        end
        n_tests++; if (mon_both != 0 || mon_bad_grant != 0) begin
            n_fail++; $display("FAIL alt_exclusive: got both_rd=%0d bad_grant=%0d want 0/0", mon_both, mon_bad_grant);
        end
    endtask

    task automatic test_truncate();
        int eofs = 0;
        do_reset();
        push_frame(1, 2000);
        run_model(1);
        bus.enable = 1'b1;
        wait_idle(3000, "trunc");
        foreach (outq[i]) if (outq[i][EOF_BIT]) eofs++;
        n_tests++; if (outq.size() != int'(MAX_LEN)) begin n_fail++; $display("FAIL trunc_len: got %0d words want %0d", outq.size(), MAX_LEN); end
        n_tests++; if (eofs != 1 || outq.size() == 0 || outq[outq.size()-1][EOF_BIT] !== 1'b1) begin
            n_fail++; $display("FAIL trunc_eof: got %0d EOF words want 1 on the last word", eofs);
        end
        n_tests++; if (stream_errors() != 0) begin n_fail++; $display("FAIL trunc_stream: got %0d word errors want 0", stream_errors()); end
        n_tests++; if (bus.trunc_cnt !== 16'd1 || bus.frame_cnt1 !== 16'd1) begin
            n_fail++; $display("FAIL trunc_cnt: got trunc=%0d cnt1=%0d want 1/1", bus.trunc_cnt, bus.frame_cnt1);
        end
        n_tests++; if (rxq1.size() != 0) begin n_fail++; $display("FAIL trunc_drain: got %0d words left want 0", rxq1.size()); end
    endtask

    task automatic test_backpressure();
        int c = 0;
        bit done = 1'b0;
        do_reset();
        drain_all = 1'b0;
        push_frame(0, 100);
        run_model(1);
        bus.enable = 1'b1;
        while (!done && c < 2000) begin
            @(posedge sys_clk); #1;
            c++;
            if (c % 3 == 0) force_full = !force_full;
            if (rxq0.size() == 0 && bus.grant == 2'b00 && !bus.wr_en) done = 1'b1;
        end
        force_full = 1'b0;
        n_tests++; if (!done) begin n_fail++; $display("FAIL bp_timeout: got %0d words left want 0", rxq0.size()); end
        n_tests++; if (mon_pop_full != 0) begin n_fail++; $display("FAIL bp_pop_full: got %0d pops while full want 0", mon_pop_full); end
        n_tests++; if (mon_ovf != 0) begin n_fail++; $display("FAIL bp_overflow: got %0d overflows want 0", mon_ovf); end
        n_tests++; if (stream_errors() != 0) begin n_fail++; $display("FAIL bp_stream: got %0d word errors want 0", stream_errors()); end
    endtask

    task automatic test_random();
        for (int round = 0; round < 3; round++) begin
            int c = 0;
            bit done = 1'b0;
            do_reset();
            drain_all = 1'b0;
            for (int f = 0; f < 8; f++) push_frame(int'($urandom_range(1, 0)), int'($urandom_range(40, 1)));
            run_model(1);
            bus.enable = 1'b1;
            while (!done && c < 3000) begin
                @(posedge sys_clk); #1;
                c++;
                force_full = ($urandom_range(3, 0) == 0);
                if (rxq0.size() == 0 && rxq1.size() == 0 && bus.grant == 2'b00 && !bus.wr_en) done = 1'b1;
            end
            force_full = 1'b0;
            n_tests++; if (!done) begin n_fail++; $display("FAIL rnd%0d_timeout: got rx0=%0d rx1=%0d left want 0", round, rxq0.size(), rxq1.size()); end
            n_tests++; if (stream_errors() != 0) begin n_fail++; $display("FAIL rnd%0d_stream: got %0d word errors want 0", round, stream_errors()); end
            n_tests++; if (order_errors() != 0) begin n_fail++; $display("FAIL rnd%0d_order: got %0d order errors want 0", round, order_errors()); end
            n_tests++; if (bus.frame_cnt0 !== CNT_W'(exp_cnt0) || bus.frame_cnt1 !== CNT_W'(exp_cnt1)) begin
                n_fail++; $display("FAIL rnd%0d_cnt: got %0d/%0d want %0d/%0d", round, bus.frame_cnt0, bus.frame_cnt1, exp_cnt0, exp_cnt1);
            end
            n_tests++; if (mon_pop_full + mon_ovf + mon_lat + mon_both != 0) begin
                n_fail++; $display("FAIL rnd%0d_protocol: got pop_full=%0d ovf=%0d lat=%0d both=%0d want 0", round, mon_pop_full, mon_ovf, mon_lat, mon_both);
            end
        end
    endtask

    task automatic test_enable();
        int busy = 0;
        int c = 0;
        do_reset();
        for (int i = 0; i < 2; i++) begin push_frame(0, 30); push_frame(1, 30); end
        run_model(1);
        repeat (20) begin
            @(negedge sys_clk); #1;
            if (bus.grant != 2'b00) busy++;
        end
        n_tests++; if (busy != 0 || outq.size() != 0) begin n_fail++; $display("FAIL en_hold: got %0d granted cycles, %0d writes want 0/0", busy, outq.size()); end
        bus.enable = 1'b1;
        while (bus.grant == 2'b00 && c < 10) begin @(negedge sys_clk); #1; c++; end
        repeat (5) @(negedge sys_clk);
        #1 bus.enable = 1'b0;
        c = 0;
        while (bus.grant != 2'b00 && c < 200) begin @(negedge sys_clk); #1; c++; end
        busy = 0;
        repeat (20) begin
            @(negedge sys_clk); #1;
            if (bus.grant != 2'b00) busy++;
        end
        n_tests++; if (outq.size() != 30 || outq[29][EOF_BIT] !== 1'b1) begin
            n_fail++; $display("FAIL en_complete: got %0d words want 30 ending in EOF", outq.size());
        end
        n_tests++; if (busy != 0 || gseq.size() != 1 || gseq[0] != 0) begin
            n_fail++; $display("FAIL en_stop: got %0d granted cycles, %0d frames want 0 and 1 frame from port 0", busy, gseq.size());
        end
        bus.enable = 1'b1;
        wait_idle(600, "en_resume");
        n_tests++; if (stream_errors() != 0 || order_errors() != 0) begin
            n_fail++; $display("FAIL en_resume_stream: got %0d word and %0d order errors want 0/0", stream_errors(), order_errors());
        end
    endtask

    task automatic test_reset_mid();
        int c = 0;
        do_reset();
        push_frame(1, 50);
        bus.enable = 1'b1;
        while (bus.grant == 2'b00 && c < 20) begin @(negedge sys_clk); #1; c++; end
        repeat (10) @(negedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (bus.grant !== 2'b00 || bus.wr_en !== 1'b0 || bus.wr_data !== 9'h0 || {bus.rd0_en, bus.rd1_en} !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset_outputs: got grant=%b wr_en=%b wr_data=%h rd=%b want all 0",
                               bus.grant, bus.wr_en, bus.wr_data, {bus.rd0_en, bus.rd1_en});
        end
        n_tests++; if (bus.frame_cnt0 !== '0 || bus.frame_cnt1 !== '0 || bus.trunc_cnt !== '0) begin
            n_fail++; $display("FAIL mid_reset_counters: got %0d/%0d/%0d want 0/0/0", bus.frame_cnt0, bus.frame_cnt1, bus.trunc_cnt);
        end
        // tx FIFO is flushed by the same reset; the rx remainder of port 1 stays queued
        tx_occ = 0;
        outq.delete();
        gseq.delete();
        push_frame(0, 10);
        repeat (2) @(posedge sys_clk);
        #1 reset_n = 1'b1;
        c = 0;
        while (bus.grant == 2'b00 && c < 10) begin @(negedge sys_clk); #1; c++; end
        n_tests++; if (bus.grant !== 2'b01) begin n_fail++; $display("FAIL mid_first_grant: got %b want 01", bus.grant); end
        wait_idle(400, "mid_finish");
        n_tests++; if (bus.frame_cnt0 !== 16'd1 || bus.frame_cnt1 !== 16'd1) begin
            n_fail++; $display("FAIL mid_cnt: got %0d/%0d want 1/1", bus.frame_cnt0, bus.frame_cnt1);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        bus.enable = 1'b0;
        force_full = 1'b0;
        drain_all  = 1'b1;
        tx_occ     = 0;
        test_reset();
        test_single_frame();
        test_alternate();
        test_truncate();
        test_backpressure();
        test_random();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
